// File: rtl/fifo_wr_arb.sv
// Two-requester write arbiter in front of a FIFO write port. Grants are
// combinational and bounded by a per-owner burst limit; writes are counted.
module fifo_wr_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req0,
    input  logic [2*DATA_WIDTH-1:0]   data0,
    output logic                      ack0,
    input  logic                      req1,
    input  logic [2*DATA_WIDTH-1:0]   data1,
    output logic                      ack1,
    input  logic                      full,
    output logic                      wr,
    output logic [2*DATA_WIDTH-1:0]   w_data,
    output logic                      owner,
    output logic [15:0]               wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_C = 4'(BURST);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        last_gnt_r, last_gnt_s;
    logic [15:0] wr_count_r, wr_count_s;
    logic        any_req_s;
    logic        sel_s;
    logic        grant_s;

    // State register: all arbiter state, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            last_gnt_r <= 1'b1;
            wr_count_r <= 16'd0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            last_gnt_r <= last_gnt_s;
            wr_count_r <= wr_count_s;
        end
    end

    // Requester selection: the owner keeps the port until its burst is spent
    // and the other side is waiting; from IDLE the least recent grantee wins.
    always_comb begin
        any_req_s = req0 | req1;
        sel_s     = 1'b0;
        case (state_r)
            OWN0: begin
                if (req0 && ((cnt_r < BURST_C) || !req1)) begin
                    sel_s = 1'b0;
                end else if (req1) begin
                    sel_s = 1'b1;
                end else begin
                    sel_s = 1'b0;
                end
            end
            OWN1: begin
                if (req1 && ((cnt_r < BURST_C) || !req0)) begin
                    sel_s = 1'b1;
                end else if (req0) begin
                    sel_s = 1'b0;
                end else begin
                    sel_s = 1'b1;
                end
            end
            default: begin
                if (req0 && req1) begin
                    sel_s = ~last_gnt_r;
                end else if (req1) begin
                    sel_s = 1'b1;
                end else begin
                    sel_s = 1'b0;
                end
            end
        endcase
        grant_s = any_req_s & ~full & reset;
    end

    // Next-state: a full FIFO freezes ownership and the burst count.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        last_gnt_s = last_gnt_r;
        wr_count_s = wr_count_r;
        if (!any_req_s) begin
            state_s = IDLE;
            cnt_s   = 4'd0;
        end else if (grant_s) begin
            state_s    = sel_s ? OWN1 : OWN0;
            last_gnt_s = sel_s;
            if (state_s == state_r) begin
                cnt_s = (cnt_r < BURST_C) ? (cnt_r + 4'd1) : cnt_r;
            end else begin
                // The granting cycle itself is the first word of the new burst.
                cnt_s = 4'd1;
            end
        end else begin
            state_s = state_r;
            cnt_s   = cnt_r;
        end
        if (grant_s && (wr_count_r != 16'hFFFF)) begin
            wr_count_s = wr_count_r + 16'd1;
        end else begin
            wr_count_s = wr_count_r;
        end
    end

    // Outputs: write strobe, acks and data follow the grant in the same cycle.
    always_comb begin
        wr       = grant_s;
        ack0     = grant_s & ~sel_s;
        ack1     = grant_s & sel_s;
        owner    = (state_r == OWN1);
        wr_count = wr_count_r;
        if (grant_s) begin
            w_data = sel_s ? data1 : data0;
        end else begin
            w_data = {(2*DATA_WIDTH){1'b0}};
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb (DATA_WIDTH=8, BURST=4): one task per scenario,
// inputs driven at the falling edge, outputs sampled 1ns later.
module tb_fifo_wr_arb;

    logic        clk;
    logic        reset;
    logic        req0, req1, full;
    logic [15:0] data0, data1;
    logic        ack0, ack1, wr, owner;
    logic [15:0] w_data;
    logic [15:0] wr_count;

    int tests;
    int fails;

    fifo_wr_arb #(.DATA_WIDTH(8), .BURST(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .data0    (data0),
        .ack0     (ack0),
        .req1     (req1),
        .data1    (data1),
        .ack1     (ack1),
        .full     (full),
        .wr       (wr),
        .w_data   (w_data),
        .owner    (owner),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        full  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1; full = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if ({wr, ack0, ack1, owner} !== 4'b0000) begin
            fails++; $display("FAIL reset_ctl: got wr/ack0/ack1/owner=%b want 0000", {wr, ack0, ack1, owner});
        end
        tests++;
        if (w_data !== 16'h0000) begin
            fails++; $display("FAIL reset_wdata: got %h want 0000", w_data);
        end
        tests++;
        if (wr_count !== 16'd0) begin
            fails++; $display("FAIL reset_count: got %0d want 0", wr_count);
        end
    endtask

    task automatic test_single;
        do_reset;
        req0 = 1'b1; req1 = 1'b0; full = 1'b0;
        #1;
        tests++;
        if ({wr, ack0, ack1, owner} !== 4'b1100) begin
            fails++; $display("FAIL single_ctl: got wr/ack0/ack1/owner=%b want 1100", {wr, ack0, ack1, owner});
        end
        tests++;
        if (w_data !== 16'hA5A5) begin
            fails++; $display("FAIL single_wdata: got %h want a5a5", w_data);
        end
        @(negedge clk);
        req0 = 1'b0;
        #1;
        tests++;
        if (wr_count !== 16'd1) begin
            fails++; $display("FAIL single_count: got %0d want 1", wr_count);
        end
        tests++;
        if ({wr, w_data} !== 17'd0) begin
            fails++; $display("FAIL single_idle: got wr=%b w_data=%h want 0/0000", wr, w_data);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_sel, exp_owner;
        do_reset;
        req0 = 1'b1; req1 = 1'b1;
        exp_owner = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_sel = (i >= 4 && i < 8) ? 1'b1 : 1'b0;
            tests++;
            if ({wr, ack0, ack1, owner} !== {1'b1, ~exp_sel, exp_sel, exp_owner}) begin
                fails++; $display("FAIL b2b_ctl[%0d]: got wr/ack0/ack1/owner=%b want %b", i,
                                  {wr, ack0, ack1, owner}, {1'b1, ~exp_sel, exp_sel, exp_owner});
            end
            tests++;
            if (w_data !== (exp_sel ? 16'h5A5A : 16'hA5A5)) begin
                fails++; $display("FAIL b2b_wdata[%0d]: got %h", i, w_data);
            end
            if (i == 8) begin
                tests++;
                if (wr_count !== 16'd8) begin
                    fails++; $display("FAIL b2b_count: got %0d want 8", wr_count);
                end
            end
            exp_owner = exp_sel;
        end
    endtask

    task automatic test_full_stall;
        do_reset;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            tests++;
            if ({wr, ack0, ack1, owner} !== 4'b0000) begin
                fails++; $display("FAIL stall_ctl[%0d]: got wr/ack0/ack1/owner=%b want 0000", i, {wr, ack0, ack1, owner});
            end
        end
        tests++;
        if (wr_count !== 16'd2) begin
            fails++; $display("FAIL stall_count: got %0d want 2", wr_count);
        end
        @(negedge clk);
        full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            tests++;
            if ({ack0, ack1} !== ((i < 2) ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL stall_resume[%0d]: got ack0/ack1=%b want %b", i, {ack0, ack1},
                                  (i < 2) ? 2'b10 : 2'b01);
            end
        end
    endtask

    task automatic test_alone;
        int acks;
        do_reset;
        req0 = 1'b1; req1 = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (ack0 === 1'b1 && owner === 1'b0) acks++;
        end
        tests++;
        if (acks !== 10) begin
            fails++; $display("FAIL alone_acks: got %0d ack0 cycles want 10", acks);
        end
        @(negedge clk);
        req1 = 1'b1;
        #1;
        tests++;
        if ({ack0, ack1} !== 2'b01) begin
            fails++; $display("FAIL alone_yield: got ack0/ack1=%b want 01", {ack0, ack1});
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        req0 = 1'b0; req1 = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if ({ack1, owner} !== 2'b11) begin
            fails++; $display("FAIL mid_own1: got ack1/owner=%b want 11", {ack1, owner});
        end
        @(negedge clk);
        reset = 1'b0; req0 = 1'b1;
        #1;
        tests++;
        if ({wr, ack0, ack1, w_data} !== 19'd0) begin
            fails++; $display("FAIL mid_forced: got wr=%b ack0=%b ack1=%b w_data=%h want all 0", wr, ack0, ack1, w_data);
        end
        @(negedge clk);
        #1;
        tests++;
        if ({wr, owner} !== 2'b00) begin
            fails++; $display("FAIL mid_held: got wr/owner=%b want 00", {wr, owner});
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({ack0, ack1} !== 2'b10) begin
            fails++; $display("FAIL mid_release: got ack0/ack1=%b want 10", {ack0, ack1});
        end
    endtask

    task automatic test_saturate;
        do_reset;
        force dut.wr_count_r = 16'hFFFE;
        #1;
        release dut.wr_count_r;
        #1;
        tests++;
        if (wr_count !== 16'hFFFE) begin
            fails++; $display("FAIL sat_preload: got %h want fffe", wr_count);
        end
        req0 = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (wr_count !== 16'hFFFF) begin
            fails++; $display("FAIL sat_first: got %h want ffff", wr_count);
        end
        @(negedge clk);
        @(negedge clk);
        req0 = 1'b0;
        #1;
        tests++;
        if (wr_count !== 16'hFFFF) begin
            fails++; $display("FAIL sat_hold: got %h want ffff", wr_count);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        full  = 1'b0;
        data0 = 16'hA5A5;
        data1 = 16'h5A5A;
        test_reset;
        test_single;
        test_back_to_back;
        test_full_stall;
        test_alone;
        test_reset_mid;
        test_saturate;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
